// File: rtl/select_next_hop_if.sv
// select_next_hop_if: request/result and routing-table read bus of select_next_hop.
// slave  = the search engine (select_next_hop)
// master = the requester plus the routing-table memory
interface select_next_hop_if;
  logic        en;
  logic [15:0] sinkID;
  logic [15:0] data_in;
  logic [10:0] address;
  logic        done;
  logic        hop_valid;
  logic [15:0] hop_ID;
  logic [15:0] hop_qValue;
  logic [15:0] hop_battery;

  modport slave (
    input  en, sinkID, data_in,
    output address, done, hop_valid, hop_ID, hop_qValue, hop_battery
  );

  modport master (
    output en, sinkID, data_in,
    input  address, done, hop_valid, hop_ID, hop_qValue, hop_battery
  );
endinterface

// File: rtl/select_next_hop.sv
// select_next_hop: walks the routing table (read-only) and picks the neighbor
// advertising sinkID with the lowest qValue. Lower neighbor index wins ties.
// Optional feature macro: BATTERY_TIEBREAK_EN -- on equal qValue, the candidate
// with the strictly higher batteryStat replaces the current best.
// Memory read timing: address registered at edge t, data_in sampled at edge t+1.
module select_next_hop (
  input  logic              clock,
  input  logic              rst,
  select_next_hop_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_NCNT,
    S_NEXT,
    S_LD_SCNT,
    S_SINK,
    S_CMP,
    S_LD_Q,
    S_LD_B,
    S_LD_ID,
    S_DONE
  } state_t;

  localparam logic [10:0] ADDR_NCNT  = 11'h68A;
  localparam logic [10:0] ADDR_NID   = 11'h048;
  localparam logic [10:0] ADDR_BAT   = 11'h148;
  localparam logic [10:0] ADDR_Q     = 11'h1C8;
  localparam logic [10:0] ADDR_SCNT  = 11'h68E;
  localparam logic [10:0] ADDR_SINKS = 11'h248;

  state_t      state_q, state_d;
  logic [6:0]  n_q, n_d;
  logic [3:0]  k_q, k_d;
  logic [6:0]  ncnt_q, ncnt_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [15:0] q_q, q_d;
  logic [15:0] bat_q, bat_d;
  logic        best_valid_q, best_valid_d;
  logic [15:0] best_id_q, best_id_d;
  logic [15:0] best_q_q, best_q_d;
  logic [15:0] best_bat_q, best_bat_d;
  logic [10:0] address_q, address_d;
  logic        done_q, done_d;
  logic        hop_valid_q, hop_valid_d;
  logic [15:0] hop_id_q, hop_id_d;
  logic [15:0] hop_qv_q, hop_qv_d;
  logic [15:0] hop_bat_q, hop_bat_d;

  logic        take_cand;
  logic [10:0] n_x2;
  logic [10:0] n_x16;
  logic [10:0] k_x2;

  assign n_x2  = {3'b000, n_q, 1'b0};
  assign n_x16 = {n_q, 4'b0000};
  assign k_x2  = {6'b000000, k_q, 1'b0};

  // Decide whether the just-loaded candidate beats the current best.
  always_comb begin
    take_cand = !best_valid_q || (q_q < best_q_q);
`ifdef BATTERY_TIEBREAK_EN
    if (best_valid_q && (q_q == best_q_q) && (bat_q > best_bat_q)) begin
      take_cand = 1'b1;
    end
`endif
  end

  // Next-state and datapath updates for the search sequence.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    k_d          = k_q;
    ncnt_d       = ncnt_q;
    scnt_d       = scnt_q;
    q_d          = q_q;
    bat_d        = bat_q;
    best_valid_d = best_valid_q;
    best_id_d    = best_id_q;
    best_q_d     = best_q_q;
    best_bat_d   = best_bat_q;
    address_d    = address_q;
    done_d       = done_q;
    hop_valid_d  = hop_valid_q;
    hop_id_d     = hop_id_q;
    hop_qv_d     = hop_qv_q;
    hop_bat_d    = hop_bat_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          n_d          = '0;
          k_d          = '0;
          best_valid_d = 1'b0;
          best_id_d    = '0;
          best_q_d     = '0;
          best_bat_d   = '0;
          done_d       = 1'b0;
          hop_valid_d  = 1'b0;
          address_d    = ADDR_NCNT;
          state_d      = S_LD_NCNT;
        end
      end
      S_LD_NCNT: begin
        ncnt_d  = (bus.data_in > 16'd64) ? 7'd64 : bus.data_in[6:0];
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (n_q == ncnt_q) begin
          state_d = S_DONE;
        end else begin
          address_d = ADDR_SCNT + n_x2;
          state_d   = S_LD_SCNT;
        end
      end
      S_LD_SCNT: begin
        scnt_d  = (bus.data_in > 16'd8) ? 4'd8 : bus.data_in[3:0];
        k_d     = '0;
        state_d = S_SINK;
      end
      S_SINK: begin
        if (k_q == scnt_q) begin
          n_d     = n_q + 7'd1;
          state_d = S_NEXT;
        end else begin
          address_d = ADDR_SINKS + n_x16 + k_x2;
          state_d   = S_CMP;
        end
      end
      S_CMP: begin
        // First match ends this neighbor's scan, so duplicates never re-evaluate it.
        if (bus.data_in == bus.sinkID) begin
          address_d = ADDR_Q + n_x2;
          state_d   = S_LD_Q;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_SINK;
        end
      end
      S_LD_Q: begin
        q_d       = bus.data_in;
        address_d = ADDR_BAT + n_x2;
        state_d   = S_LD_B;
      end
      S_LD_B: begin
        bat_d     = bus.data_in;
        address_d = ADDR_NID + n_x2;
        state_d   = S_LD_ID;
      end
      S_LD_ID: begin
        if (take_cand) begin
          best_valid_d = 1'b1;
          best_id_d    = bus.data_in;
          best_q_d     = q_q;
          best_bat_d   = bat_q;
        end
        n_d     = n_q + 7'd1;
        state_d = S_NEXT;
      end
      S_DONE: begin
        hop_valid_d = best_valid_q;
        hop_id_d    = best_id_q;
        hop_qv_d    = best_q_q;
        hop_bat_d   = best_bat_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      k_q          <= '0;
      ncnt_q       <= '0;
      scnt_q       <= '0;
      q_q          <= '0;
      bat_q        <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_q_q     <= '0;
      best_bat_q   <= '0;
      address_q    <= '0;
      done_q       <= 1'b0;
      hop_valid_q  <= 1'b0;
      hop_id_q     <= '0;
      hop_qv_q     <= '0;
      hop_bat_q    <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      ncnt_q       <= ncnt_d;
      scnt_q       <= scnt_d;
      q_q          <= q_d;
      bat_q        <= bat_d;
      best_valid_q <= best_valid_d;
      best_id_q    <= best_id_d;
      best_q_q     <= best_q_d;
      best_bat_q   <= best_bat_d;
      address_q    <= address_d;
      done_q       <= done_d;
      hop_valid_q  <= hop_valid_d;
      hop_id_q     <= hop_id_d;
      hop_qv_q     <= hop_qv_d;
      hop_bat_q    <= hop_bat_d;
    end
  end

  assign bus.address     = address_q;
  assign bus.done        = done_q;
  assign bus.hop_valid   = hop_valid_q;
  assign bus.hop_ID      = hop_id_q;
  assign bus.hop_qValue  = hop_qv_q;
  assign bus.hop_battery = hop_bat_q;

endmodule

// File: tb/tb_select_next_hop.sv
// tb_select_next_hop: directed searches against a byte-addressed routing-table
// model; expected results are queued at request time and checked when done rises.
module tb_select_next_hop;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  select_next_hop_if bus ();

  logic [15:0] mem [0:2047];
  assign bus.data_in = mem[bus.address];

  select_next_hop dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        valid;
    logic [15:0] id;
    logic [15:0] q;
    logic [15:0] bat;
    int          lat;
    int unsigned t0;
  } exp_t;

  exp_t        sbq [$];
  int unsigned checks = 0;
  int unsigned fails  = 0;
  int unsigned cyc    = 0;
  logic        done_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the oldest queued expectation on each rising done.
  always @(negedge clock) begin
    exp_t e;
    if (!rst && bus.done && !done_prev) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done at t=%0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("hop_valid",   bus.hop_valid,   e.valid);
        chk("hop_ID",      bus.hop_ID,      e.id);
        chk("hop_qValue",  bus.hop_qValue,  e.q);
        chk("hop_battery", bus.hop_battery, e.bat);
        if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
      end
    end
    done_prev = bus.done;
  end

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  task automatic set_nb(input int n, input logic [15:0] id, input logic [15:0] q,
                        input logic [15:0] bat, input logic [15:0] scnt);
    mem[32'h048 + 2*n] = id;
    mem[32'h148 + 2*n] = bat;
    mem[32'h1C8 + 2*n] = q;
    mem[32'h68E + 2*n] = scnt;
  endtask

  task automatic set_sink(input int n, input int k, input logic [15:0] v);
    mem[32'h248 + 16*n + 2*k] = v;
  endtask

  task automatic start(input logic v, input logic [15:0] id, input logic [15:0] q,
                       input logic [15:0] bat, input int lat);
    exp_t e;
    e.valid = v; e.id = id; e.q = q; e.bat = bat; e.lat = lat;
    @(negedge clock);
    bus.en = 1'b1;
    @(posedge clock);
    #1;
    e.t0 = cyc;
    sbq.push_back(e);
    bus.en = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", n);
      sbq.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic setup_three();
    clear_mem();
    mem[12'h68A] = 16'd3;
    set_nb(0, 16'd5, 16'd40, 16'd1, 16'd1); set_sink(0, 0, 16'h000A);
    set_nb(1, 16'd7, 16'd20, 16'd2, 16'd1); set_sink(1, 0, 16'h000A);
    set_nb(2, 16'd9, 16'd30, 16'd3, 16'd1); set_sink(2, 0, 16'h000A);
  endtask

  initial begin
    bus.en     = 1'b0;
    bus.sinkID = 16'h000A;
    clear_mem();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_address",   bus.address,     0);
    chk("rst_done",      bus.done,        0);
    chk("rst_hop_valid", bus.hop_valid,   0);
    chk("rst_hop_ID",    bus.hop_ID,      0);
    rst = 1'b0;

    // Empty table: done three cycles after the accepting edge, all zero.
    start(1'b0, 16'd0, 16'd0, 16'd0, 3);
    wait_done();

    // One neighbor, match at k=0.
    clear_mem();
    mem[12'h68A] = 16'd1;
    set_nb(0, 16'h1234, 16'h0099, 16'h0055, 16'd1); set_sink(0, 0, 16'h000A);
    start(1'b1, 16'h1234, 16'h0099, 16'h0055, 10);
    wait_done();

    // Three neighbors, lowest q in the middle.
    setup_three();
    start(1'b1, 16'd7, 16'd20, 16'd2, 24);
    wait_done();

    // Equal q, battery decides only with the tiebreak feature.
    clear_mem();
    mem[12'h68A] = 16'd2;
    set_nb(0, 16'd5, 16'd20, 16'd10, 16'd1); set_sink(0, 0, 16'h000A);
    set_nb(1, 16'd7, 16'd20, 16'd50, 16'd1); set_sink(1, 0, 16'h000A);
`ifdef BATTERY_TIEBREAK_EN
    start(1'b1, 16'd7, 16'd20, 16'd50, 17);
`else
    start(1'b1, 16'd5, 16'd20, 16'd10, 17);
`endif
    wait_done();

    // sinkIDCount 12 clamps to 8; the match at k=10 is never read.
    clear_mem();
    mem[12'h68A] = 16'd1;
    set_nb(0, 16'd3, 16'd1, 16'd1, 16'd12);
    for (int k = 0; k < 12; k++) set_sink(0, k, 16'h0001);
    set_sink(0, 10, 16'h000A);
    start(1'b0, 16'd0, 16'd0, 16'd0, 22);
    wait_done();

    // No match on neighbor 0; match at k=1 on neighbor 1 followed by a duplicate.
    clear_mem();
    mem[12'h68A] = 16'd2;
    set_nb(0, 16'h0011, 16'h0001, 16'h0001, 16'd2);
    set_sink(0, 0, 16'h0001); set_sink(0, 1, 16'h0002);
    set_nb(1, 16'h0077, 16'h0100, 16'h0200, 16'd3);
    set_sink(1, 0, 16'h0003); set_sink(1, 1, 16'h000A); set_sink(1, 2, 16'h000A);
    start(1'b1, 16'h0077, 16'h0100, 16'h0200, 19);
    wait_done();

    // neighborCount 100 clamps to 64: neighbor 63 wins, neighbor 64 never scanned.
    clear_mem();
    mem[12'h68A] = 16'd100;
    set_nb(63, 16'h0063, 16'd5, 16'd6, 16'd1); set_sink(63, 0, 16'h000A);
    set_nb(64, 16'h0064, 16'd0, 16'd0, 16'd1); set_sink(64, 0, 16'h000A);
    start(1'b1, 16'h0063, 16'd5, 16'd6, 199);
    wait_done();

    // Reset while the first neighbor is in CMP, then a clean rerun.
    setup_three();
    @(negedge clock);
    bus.en = 1'b1;
    @(posedge clock);
    #1;
    bus.en = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    chk("midrst_address",     bus.address,     0);
    chk("midrst_done",        bus.done,        0);
    chk("midrst_hop_valid",   bus.hop_valid,   0);
    chk("midrst_hop_ID",      bus.hop_ID,      0);
    chk("midrst_hop_qValue",  bus.hop_qValue,  0);
    chk("midrst_hop_battery", bus.hop_battery, 0);
    start(1'b1, 16'd7, 16'd20, 16'd2, 24);
    wait_done();

    // en re-pulsed mid-search must be ignored.
    setup_three();
    start(1'b1, 16'd7, 16'd20, 16'd2, 24);
    repeat (6) @(negedge clock);
    bus.en = 1'b1;
    @(negedge clock);
    bus.en = 1'b0;
    wait_done();
    chk("ignored_en_no_extra_done", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
